// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
//   Front-end fetch stage. Owns the PC, the single-outstanding instruction
//   memory request handshake and the IF/ID pipeline register. Tolerates
//   variable memory latency and obeys stall/flush/redirect controls coming
//   from the hazard detection unit.
//
// Ports
//   clk, rst_n        clock (rising edge), async active-low reset
//   PC_Write          1 = PC may update this cycle
//   IF_ID_Write       1 = IF/ID may load this cycle
//   PC_Mux_select     00 seq, 01 branch, 10 jump, 11 hold
//   IF_ID_Mux_select  1 = flush IF/ID to a bubble
//   branch_target     redirect address for select 01
//   jump_target       redirect address for select 10
//   imem_req/addr     fetch request and address (out)
//   imem_ack/rdata    fetch data valid and instruction word (in)
//   IF_ID_PC          PC+4 of the instruction held in IF/ID
//   IF_ID_Instr       instruction held in IF/ID
//   IF_ID_Valid       0 = IF/ID holds a bubble
//   fetch_stall       IF/ID wants to advance but nothing is available
//
// Build option
//   IF_FETCH_PERF_CNT_EN  adds perf_stall_cnt / perf_redirect_cnt (saturating)
//
// States
//   IDLE  | first cycle after reset, no request
//   FETCH | request outstanding at PC
//   HOLD  | fetched word parked in buffer while the pipe is stalled
//   DRAIN | redirected mid-fetch; wait out the stale ack and drop its data
// ---------------------------------------------------------------------------
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] BUBBLE_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PC_Write,
  input  logic        IF_ID_Write,
  input  logic [1:0]  PC_Mux_select,
  input  logic        IF_ID_Mux_select,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_ID_PC,
  output logic [31:0] IF_ID_Instr,
  output logic        IF_ID_Valid,
  output logic        fetch_stall
`ifdef IF_FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_redirect_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] drain_addr_q, drain_addr_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic        ifid_valid_q, ifid_valid_d;

  logic        redirect;
  logic [31:0] redirect_pc;
  logic        avail;
  logic [31:0] avail_instr;
  logic        advance;
  logic [31:0] pc_plus4;

  assign redirect    = PC_Write && (PC_Mux_select == 2'b01 || PC_Mux_select == 2'b10);
  assign redirect_pc = (PC_Mux_select == 2'b01) ? branch_target : jump_target;
  assign avail       = (state_q == FETCH && imem_ack) || (state_q == HOLD);
  assign avail_instr = (state_q == HOLD) ? buf_q : imem_rdata;
  assign pc_plus4    = pc_q + 32'd4;
  assign advance     = !redirect && PC_Write && (PC_Mux_select == 2'b00) &&
                       IF_ID_Write && !IF_ID_Mux_select && avail;

  assign imem_req    = (state_q == FETCH) || (state_q == DRAIN);
  // DRAIN keeps presenting the abandoned address so the request stays stable
  // until its ack, even though PC already points at the redirect target.
  assign imem_addr   = (state_q == DRAIN) ? drain_addr_q : pc_q;
  // IDLE only exists directly after reset; no stall is reported there.
  assign fetch_stall = IF_ID_Write && PC_Write && !redirect && !avail && (state_q != IDLE);

  assign IF_ID_PC    = ifid_pc_q;
  assign IF_ID_Instr = ifid_instr_q;
  assign IF_ID_Valid = ifid_valid_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    buf_d        = buf_q;
    drain_addr_d = drain_addr_q;

    case (state_q)
      IDLE:  state_d = FETCH;
      FETCH: begin
        if (redirect) begin
          if (!imem_ack) begin
            state_d      = DRAIN;
            drain_addr_d = pc_q;
          end
        end else if (!advance && imem_ack) begin
          buf_d   = imem_rdata;
          state_d = HOLD;
        end
      end
      HOLD:  if (redirect || advance) state_d = FETCH;
      DRAIN: if (imem_ack) state_d = FETCH;
      default: state_d = IDLE;
    endcase

    if (redirect)      pc_d = redirect_pc;
    else if (advance)  pc_d = pc_plus4;
  end

  always_comb begin
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    if (IF_ID_Mux_select) begin
      ifid_pc_d    = 32'h0;
      ifid_instr_d = BUBBLE_INSTR;
      ifid_valid_d = 1'b0;
    end else if (IF_ID_Write && advance) begin
      ifid_pc_d    = pc_plus4;
      ifid_instr_d = avail_instr;
      ifid_valid_d = 1'b1;
    end else if (IF_ID_Write && !avail) begin
      ifid_pc_d    = 32'h0;
      ifid_instr_d = BUBBLE_INSTR;
      ifid_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      buf_q        <= 32'h0;
      drain_addr_q <= 32'h0;
      ifid_pc_q    <= 32'h0;
      ifid_instr_q <= BUBBLE_INSTR;
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      buf_q        <= buf_d;
      drain_addr_q <= drain_addr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

`ifdef IF_FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt_q, redirect_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q    <= 32'h0;
      redirect_cnt_q <= 32'h0;
    end else begin
      if (fetch_stall && stall_cnt_q != 32'hFFFF_FFFF)
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (redirect && redirect_cnt_q != 32'hFFFF_FFFF)
        redirect_cnt_q <= redirect_cnt_q + 32'd1;
    end
  end

  assign perf_stall_cnt    = stall_cnt_q;
  assign perf_redirect_cnt = redirect_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        PC_Write, IF_ID_Write, IF_ID_Mux_select;
  logic [1:0]  PC_Mux_select;
  logic [31:0] branch_target, jump_target;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] IF_ID_PC, IF_ID_Instr;
  logic        IF_ID_Valid, fetch_stall;

  logic        w_req, w_valid, w_stall;
  logic [31:0] w_addr, w_pc, w_instr;

  int checks = 0;
  int errors = 0;
  logic [63:0] sb_q[$];
  logic [31:0] exp_pc;

  always #5 clk = ~clk;

  if_fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write),
    .PC_Mux_select(PC_Mux_select), .IF_ID_Mux_select(IF_ID_Mux_select),
    .branch_target(branch_target), .jump_target(jump_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .IF_ID_PC(IF_ID_PC), .IF_ID_Instr(IF_ID_Instr),
    .IF_ID_Valid(IF_ID_Valid), .fetch_stall(fetch_stall)
  );

  if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst_n(rst_n), .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write),
    .PC_Mux_select(PC_Mux_select), .IF_ID_Mux_select(IF_ID_Mux_select),
    .branch_target(branch_target), .jump_target(jump_target),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .IF_ID_PC(w_pc), .IF_ID_Instr(w_instr),
    .IF_ID_Valid(w_valid), .fetch_stall(w_stall)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory model answers with addr|0x1000 whenever it acks.
  task automatic drive(input logic pcw, input logic ifw, input logic [1:0] sel,
                       input logic fl, input logic ack);
    PC_Write         = pcw;
    IF_ID_Write      = ifw;
    PC_Mux_select    = sel;
    IF_ID_Mux_select = fl;
    imem_ack         = ack;
    #1;
    imem_rdata       = imem_addr | 32'h1000;
    #1;
  endtask

  task automatic clk_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_pop(input string tag);
    logic [63:0] e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed empty scoreboard expected entry", tag);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_instr"}, IF_ID_Instr, e[63:32]);
      chk({tag, "_pc"}, IF_ID_PC, e[31:0]);
      chk({tag, "_valid"}, {31'b0, IF_ID_Valid}, 32'd1);
    end
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, "_valid"}, {31'b0, IF_ID_Valid}, 32'd0);
    chk({tag, "_instr"}, IF_ID_Instr, 32'h0);
    chk({tag, "_pc"}, IF_ID_PC, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    branch_target = 32'h0;
    jump_target   = 32'h0;
    imem_rdata    = 32'h0;
    drive(1'b1, 1'b1, 2'b00, 1'b0, 1'b0);
    #10;
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk_bubble("rst");
    chk("rst_stall", {31'b0, fetch_stall}, 32'd0);

    @(posedge clk); #1;
    rst_n = 1'b1;

    // IDLE cycle
    drive(1'b1, 1'b1, 2'b00, 1'b0, 1'b0);
    chk("idle_req", {31'b0, imem_req}, 32'd0);
    clk_edge();
    chk_bubble("idle_ifid");

    // zero-wait sequential stream, plus wrap on the second instance
    exp_pc = 32'h0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 2'b00, 1'b0, 1'b1);
      chk("seq_req", {31'b0, imem_req}, 32'd1);
      chk("seq_addr", imem_addr, exp_pc);
      if (i == 0) chk("wrap_addr0", w_addr, 32'hFFFF_FFFC);
      sb_q.push_back({exp_pc | 32'h1000, exp_pc + 32'd4});
      clk_edge();
      chk_pop("seq");
      if (i == 0) begin
        chk("wrap_addr1", w_addr, 32'h0);
        chk("wrap_ifid_pc", w_pc, 32'h0);
      end
      exp_pc = exp_pc + 32'd4;
    end

    // load-use stall while ack for 0x10 arrives
    drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
    chk("lu_addr", imem_addr, 32'h10);
    chk("lu_stall", {31'b0, fetch_stall}, 32'd0);
    clk_edge();
    chk("lu_hold_instr", IF_ID_Instr, 32'h100C);
    chk("lu_hold_pc", IF_ID_PC, 32'h10);
    drive(1'b1, 1'b1, 2'b00, 1'b0, 1'b0);
    chk("lu_hold_req", {31'b0, imem_req}, 32'd0);
    chk("lu_hold_stall", {31'b0, fetch_stall}, 32'd0);
    sb_q.push_back({32'h1010, 32'h14});
    clk_edge();
    chk_pop("lu_resume");
    exp_pc = 32'h14;

    // jump with flush while ack for 0x14 arrives
    jump_target = 32'h400;
    drive(1'b1, 1'b1, 2'b10, 1'b1, 1'b1);
    chk("jmp_addr", imem_addr, exp_pc);
    clk_edge();
    chk_bubble("jmp_flush");

    // starvation at 0x400: two cycles without ack
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 2'b00, 1'b0, 1'b0);
      chk("starve_addr", imem_addr, 32'h400);
      chk("starve_stall", {31'b0, fetch_stall}, 32'd1);
      clk_edge();
      chk_bubble("starve_ifid");
    end
    drive(1'b1, 1'b1, 2'b00, 1'b0, 1'b1);
    chk("starve_pc_kept", imem_addr, 32'h400);
    sb_q.push_back({32'h1400, 32'h404});
    clk_edge();
    chk_pop("starve_done");

    // branch redirect during a slow fetch of 0x404
    branch_target = 32'h80;
    drive(1'b1, 1'b1, 2'b01, 1'b0, 1'b0);
    chk("slow_addr0", imem_addr, 32'h404);
    chk("slow_stall0", {31'b0, fetch_stall}, 32'd0);
    clk_edge();
    chk_bubble("slow_ifid0");
    drive(1'b1, 1'b1, 2'b00, 1'b0, 1'b0);
    chk("slow_req1", {31'b0, imem_req}, 32'd1);
    chk("slow_addr1", imem_addr, 32'h404);
    clk_edge();
    drive(1'b1, 1'b1, 2'b00, 1'b0, 1'b1);
    chk("slow_addr2", imem_addr, 32'h404);
    chk("slow_stall2", {31'b0, fetch_stall}, 32'd1);
    clk_edge();
    chk_bubble("slow_dropped");
    drive(1'b1, 1'b1, 2'b00, 1'b0, 1'b1);
    chk("slow_new_req", {31'b0, imem_req}, 32'd1);
    chk("slow_new_addr", imem_addr, 32'h80);
    sb_q.push_back({32'h1080, 32'h84});
    clk_edge();
    chk_pop("slow_target");

    // enter HOLD, then async reset in the middle of the cycle
    drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
    clk_edge();
    drive(1'b1, 1'b1, 2'b00, 1'b0, 1'b0);
    chk("pre_rst_req", {31'b0, imem_req}, 32'd0);
    chk("pre_rst_valid", {31'b0, IF_ID_Valid}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_req", {31'b0, imem_req}, 32'd0);
    chk_bubble("arst");
    chk("arst_stall", {31'b0, fetch_stall}, 32'd0);
    chk("arst_addr", imem_addr, 32'h0);
    chk("arst_wrap_addr", w_addr, 32'hFFFF_FFFC);

    chk("sb_empty", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Front-end fetch stage. It owns the PC register, the instruction-memory request handshake and the IF/ID pipeline register.
- It consumes the stall, flush and redirect controls driven by the hazard detection unit: PC_Write, IF_ID_Write, PC_Mux_select and IF_ID_Mux_select.
- It sits between instruction memory and the ID stage. It supports a single outstanding fetch and variable memory latency.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded at reset.
- BUBBLE_INSTR, 32'h0000_0000, instruction word inserted on flush or starvation (MIPS sll $0,$0,0 NOP).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- PC_Write  in  1  1 = PC may update this cycle
- IF_ID_Write  in  1  1 = IF/ID may load this cycle
- PC_Mux_select  in  2  00 = sequential, 01 = branch target, 10 = jump target, 11 = hold
- IF_ID_Mux_select  in  1  1 = flush IF/ID to bubble
- branch_target  in  32  redirect address for select 01
- jump_target  in  32  redirect address for select 10
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address
- imem_ack  in  1  fetch data valid this cycle
- imem_rdata  in  32  fetched instruction
- IF_ID_PC  out  32  PC+4 of the instruction held in IF/ID
- IF_ID_Instr  out  32  instruction held in IF/ID
- IF_ID_Valid  out  1  0 = IF/ID holds a bubble
- fetch_stall  out  1  1 = IF/ID wants to advance but no instruction is available

Behaviour:
- Reset (async, rst_n=0):
  - PC=RESET_PC, state=IDLE, fetch buffer empty.
  - imem_req=0, IF_ID_Instr=BUBBLE_INSTR, IF_ID_PC=0, IF_ID_Valid=0, fetch_stall=0.
- States: IDLE, FETCH, HOLD, DRAIN.
  - IDLE: leaves for FETCH on the first clock after reset release.
  - FETCH, DRAIN: imem_req=1. Otherwise imem_req=0.
- imem_addr:
  - FETCH: equals PC.
  - DRAIN: equals the stale address.
  - imem_addr stays stable while imem_req=1. A request is never withdrawn before imem_ack.
- "Instruction available" = (FETCH and imem_ack) or HOLD.
  - The data source is imem_rdata when in FETCH, or the buffer when in HOLD.
- Redirect = PC_Write=1 and PC_Mux_select is 01 or 10. Redirect has the highest priority, in any state:
  - PC <= branch_target or jump_target. Any buffered or arriving instruction is discarded.
  - From FETCH without imem_ack: go to DRAIN, hold the old address, and discard the data when it arrives.
  - From FETCH with imem_ack, or from HOLD: go to FETCH at the new PC on the next cycle.
  - From DRAIN: stay in DRAIN and update only PC.
- DRAIN + imem_ack: data dropped, go to FETCH.
- Advance = no redirect, PC_Write=1, PC_Mux_select=00, IF_ID_Write=1, IF_ID_Mux_select=0, and an instruction is available:
  - IF_ID_Instr <= instruction, IF_ID_PC <= PC+4, IF_ID_Valid <= 1.
  - PC <= PC+4, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
  - Next state FETCH.
- Stall (PC_Write=0 or IF_ID_Write=0, no redirect, no flush):
  - IF/ID holds and PC holds.
  - FETCH with imem_ack: capture into the buffer, go to HOLD.
  - HOLD: remains in HOLD.
- PC_Mux_select=11 with PC_Write=1 behaves as a stall for PC; IF/ID still obeys the IF/ID rules below.
- IF/ID update priority, each cycle:
  1. IF_ID_Mux_select=1 flushes: IF_ID_Instr=BUBBLE_INSTR, IF_ID_Valid=0, IF_ID_PC=0, regardless of IF_ID_Write.
  2. Otherwise, if IF_ID_Write=1 and an advance occurs, load the instruction.
  3. Otherwise, if IF_ID_Write=1 and no instruction is available, load a bubble and PC holds.
  4. Otherwise hold.
- fetch_stall is combinational: IF_ID_Write=1, PC_Write=1, no redirect, and no instruction available.
- Latency: with zero-wait memory (imem_ack in the same cycle as imem_req), one instruction enters IF/ID per cycle; the first valid IF/ID appears 2 cycles after reset release.
- Reset mid-fetch: outstanding request abandoned. Memory must tolerate imem_req dropping during reset.

Optional Feature:
- Macro: IF_FETCH_PERF_CNT_EN.
- When defined, the block adds two outputs: perf_stall_cnt (32) and perf_redirect_cnt (32).
  - perf_stall_cnt increments every cycle fetch_stall=1.
  - perf_redirect_cnt increments on every redirect.
  - Both reset to 0 on rst_n=0 and saturate at 32'hFFFF_FFFF.
- When undefined, neither port nor counter logic exists; all other behaviour is identical.

Test Plan:
- Zero-wait sequential:
  - Stimulus: reset release; ack every req; rdata = addr|0x1000; controls PC_Write=1, IF_ID_Write=1, select 00, flush 0.
  - Required: IF_ID_Instr sequence 0x1000, 0x1004, 0x1008; IF_ID_PC 4, 8, 12; IF_ID_Valid=1 from cycle 2.
- Load-use stall:
  - Stimulus: mid-stream, PC_Write=0 and IF_ID_Write=0 for 1 cycle while ack for PC=0x10 arrives.
  - Required: IF/ID unchanged, state HOLD, imem_req=0. Next cycle IF/ID gets 0x1010 with no new request issued for 0x10.
- Jump with flush:
  - Stimulus: select 10, jump_target=0x400, flush=1.
  - Required: IF_ID_Valid=0 and IF_ID_Instr=0 next cycle; the following request has imem_addr=0x400.
- Redirect during outstanding slow fetch:
  - Stimulus: ack delayed 3 cycles; branch redirect to 0x80 in cycle 1.
  - Required: imem_addr holds the old address until ack; that data is never loaded into IF/ID; next request at 0x80.
- Memory starvation:
  - Stimulus: ack withheld 2 cycles with advance controls asserted.
  - Required: fetch_stall=1 both cycles; IF/ID bubbles; PC unchanged.
- Async reset mid-HOLD, plus wrap:
  - Stimulus: rst_n low asynchronously while in HOLD.
  - Required: all outputs reach reset values immediately.
  - Separately: RESET_PC=0xFFFF_FFFC fetches 0x0 second.
